exp2_pwl_eval: RTL and testbench
================================

Name: exp2_pwl_eval

Overview:
- Pipelined evaluator for the softmax exp stage. Computes 2^-(u+v) ≈ (k·v + b) >> u.
- k and b are the piecewise-linear coefficients from the coefficient lookup that sits directly upstream of this block.
- u is the integer part and v the fractional part of the log2-domain operand.
- Output feeds the softmax accumulator/normaliser through a valid/ready handshake.

Parameters:
- FRAC_W, 10, fractional bits of v, k, b and the result.
- INT_W, 8, integer bits of k, b and the result. Data width is INT_W+FRAC_W = 18.
- U_W, 5, width of the integer shift amount u.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_u  in  U_W  unsigned right-shift amount (integer part).
- in_v  in  FRAC_W  unsigned fractional part, Q0.FRAC_W.
- in_k  in  18  slope, unsigned Q8.10.
- in_b  in  18  intercept, unsigned Q8.10.
- in_last  in  1  sideband, last element of a softmax row; passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_y  out  18  result, unsigned Q8.10.
- out_last  out  1  in_last delayed with its beat.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid flags clear: out_valid=0, out_y=0, out_last=0.
  - in_ready=1 once reset releases.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Handshake:
  - A beat transfers on valid&ready at each port.
  - out_y/out_last stay stable while out_valid=1 and out_ready=0.
  - in_valid is not required to be held by upstream, but the block samples only on the transfer cycle.
- Three register stages S1, S2, S3, each with a valid bit. S3 drives the outputs.
  - S1: product P = in_k · in_v, 28 bits, full precision. Register u, b, last.
  - S2: T = (P >> FRAC_W), truncating, 18 bits. Sum = T + b, 19 bits. If Sum[18]=1, saturate to 18'h3FFFF; else Sum[17:0].
  - S3: if u >= 18, y = 0; else y = sat_sum >> u, logical shift, truncating.
- Stage advance:
  - Each stage loads when it is empty or its contents move forward in the same cycle.
  - adv3 = ~S3.valid | out_ready.
  - adv2 = ~S2.valid | adv3.
  - adv1 = ~S1.valid | adv2.
  - in_ready = adv1, combinational from out_ready and the valid flags.
  - When a stage advances with no incoming beat, its valid bit clears (bubble).
- Latency and throughput:
  - Exactly 3 cycles from input transfer to out_valid under no backpressure.
  - Throughput 1 beat/cycle.
  - Bubbles collapse: under backpressure, up to 3 beats are held, one per stage.
- Ordering: beats and their last flags exit strictly in input order; there is no reordering or dropping.
- Simultaneous events: when S3 is full and out_ready=1 in the same cycle as in_valid=1, all stages shift and the new beat enters S1.
- Widths:
  - All arithmetic is unsigned.
  - Only overflow is possible, at the S2 add, and it saturates.
  - The shift never underflows; values ≥ 18 give zero.

Decomposition:
- Shared softmax fixed-point package/config:
  - FRAC_W/INT_W constants.
  - Data width 18.
  - Saturation constant 18'h3FFFF.
- One natural sub-module: pipe_stage_ctl, the per-stage valid/advance logic. It is instantiated three times, parameterised by payload width.
- Datapath stays inline.

Test Plan:
- Basic value:
  - Stimulus: k=1024, b=1024, v=512, u=0, last=1, out_ready=1.
  - Required: after 3 cycles, out_y=1536 (1.5), out_last=1, out_valid for one cycle.
- Shift:
  - Stimulus: same k, b, v with u=1, then u=17, then u=20.
  - Required: out_y = 768, then 0 (1536>>17), then 0 (u ≥ 18 forces zero).
- Saturation:
  - Stimulus: k=18'h3FFFF, v=1023, b=18'h3FFFF, u=0.
  - Required: T=261887, Sum=524030 overflows, so out_y=18'h3FFFF. With u=2, out_y=65535.
- Backpressure:
  - Stimulus: 5 back-to-back beats with u=0..4, out_ready=0 from cycle 3 for 4 cycles.
  - Required: in_ready drops after 3 beats are held. Outputs then emerge in order 1536, 768, 384, 192, 96 with no loss or duplication, and out_y is stable while stalled.
- Bubbles:
  - Stimulus: in_valid alternating 1/0, out_ready=1.
  - Required: out_valid alternates with 3-cycle lag and in_ready stays 1.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 asynchronously with 3 beats in flight.
  - Required: out_valid=0 and out_y=0 immediately. After release, no stale beat appears, and a new beat returns its result at 3-cycle latency.

Source files
------------

// File: rtl/exp2_pwl_eval_pkg.sv
// Fixed-point config and stage payloads for the softmax exp2 evaluator.
// Q8.10 data, 5-bit shift, saturating add.
package exp2_pwl_eval_pkg;

  localparam int FRAC_W = 10;
  localparam int INT_W  = 8;
  localparam int DATA_W = INT_W + FRAC_W;
  localparam int U_W    = 5;
  localparam int PROD_W = DATA_W + FRAC_W;

  localparam logic [DATA_W-1:0] SAT_VAL = {DATA_W{1'b1}};

  typedef struct packed {
    logic [PROD_W-1:0] p;
    logic [U_W-1:0]    u;
    logic [DATA_W-1:0] b;
    logic              last;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [U_W-1:0]    u;
    logic              last;
  } s2_t;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              last;
  } s3_t;

endpackage

// File: rtl/exp2_pwl_eval_pipe_stage_ctl.sv
// One elastic pipeline register: valid bit plus payload.
// Loads when empty or when its beat moves on this cycle.
module pipe_stage_ctl #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_adv,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         adv
);

  assign adv = ~valid | dn_adv;

  // capture upstream beat, or clear to a bubble, on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/exp2_pwl_eval.sv
// Three-stage evaluator of 2^-(u+v) ~= (k*v + b) >> u.
// S1 multiply, S2 saturating add, S3 shift.
module exp2_pwl_eval
  import exp2_pwl_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [U_W-1:0]    in_u,
  input  logic [FRAC_W-1:0] in_v,
  input  logic [DATA_W-1:0] in_k,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic              out_last
);

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic s1_valid, s2_valid, s3_valid;
  logic adv1, adv2, adv3;

  logic [DATA_W-1:0] t;
  logic [DATA_W:0]   sum;
  logic              unused_lsb;

  // S1 input: full-precision product
  always_comb begin
    s1_d      = '0;
    s1_d.p    = PROD_W'(in_k) * PROD_W'(in_v);
    s1_d.u    = in_u;
    s1_d.b    = in_b;
    s1_d.last = in_last;
  end

  // S2 input: truncate product, add intercept, saturate on carry
  always_comb begin
    t         = s1_q.p[PROD_W-1:FRAC_W];
    sum       = {1'b0, t} + {1'b0, s1_q.b};
    s2_d      = '0;
    s2_d.sum  = sum[DATA_W] ? SAT_VAL : sum[DATA_W-1:0];
    s2_d.u    = s1_q.u;
    s2_d.last = s1_q.last;
  end

  // S3 input: logical right shift, zero once every bit is shifted out
  always_comb begin
    s3_d      = '0;
    s3_d.y    = (s2_q.u >= U_W'(DATA_W)) ? '0 : (s2_q.sum >> s2_q.u);
    s3_d.last = s2_q.last;
  end

  assign unused_lsb = ^s1_q.p[FRAC_W-1:0];

  pipe_stage_ctl #(.W($bits(s1_t))) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (in_valid),
    .up_data  (s1_d),
    .dn_adv   (adv2),
    .valid    (s1_valid),
    .data     (s1_q),
    .adv      (adv1)
  );

  pipe_stage_ctl #(.W($bits(s2_t))) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (s1_valid),
    .up_data  (s2_d),
    .dn_adv   (adv3),
    .valid    (s2_valid),
    .data     (s2_q),
    .adv      (adv2)
  );

  pipe_stage_ctl #(.W($bits(s3_t))) u_s3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (s2_valid),
    .up_data  (s3_d),
    .dn_adv   (out_ready),
    .valid    (s3_valid),
    .data     (s3_q),
    .adv      (adv3)
  );

  assign in_ready  = adv1;
  assign out_valid = s3_valid;
  assign out_y     = s3_q.y;
  assign out_last  = s3_q.last;

endmodule

// File: tb/tb_exp2_pwl_eval.sv
// Bench for exp2_pwl_eval: directed table, corner sequences,
// random traffic against an arithmetic reference and scoreboard.
module tb_exp2_pwl_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_u;
  logic [9:0]  in_v;
  logic [17:0] in_k;
  logic [17:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_y;
  logic        out_last;

  exp2_pwl_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_u      (in_u),
    .in_v      (in_v),
    .in_k      (in_k),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [17:0] y;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int unsigned k, v, b, u;
    bit          last;
    int unsigned y;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(string name, longint act, longint req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [17:0] ref_y(longint k, longint v, longint b,
                                        longint u);
    longint s;
    s = (k * v) / 1024 + b;
    if (s > 262143) s = 262143;
    if (u >= 18) return 18'd0;
    return 18'(s / (longint'(1) << u));
  endfunction

  // scoreboard: push on input transfer, pop and compare on output transfer
  logic        hold_valid = 1'b0;
  logic [17:0] hold_y;
  logic        hold_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        if (!out_valid) chk("held_beat_dropped", 0, 1);
        else begin
          chk("stall_y", out_y, hold_y);
          chk("stall_last", out_last, hold_last);
        end
      end
      hold_valid = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_y", out_y, e.y);
            chk("sb_last", out_last, e.last);
          end
        end else begin
          hold_valid = 1'b1;
          hold_y     = out_y;
          hold_last  = out_last;
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.y    = ref_y(in_k, in_v, in_b, in_u);
        n.last = in_last;
        exp_q.push_back(n);
      end
    end
  end

  task automatic set_in(bit vld, int unsigned k, int unsigned v,
                        int unsigned b, int unsigned u, bit last);
    in_valid = vld;
    in_k     = 18'(k);
    in_v     = 10'(v);
    in_b     = 18'(b);
    in_u     = 5'(u);
    in_last  = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(vec_t t, string tag);
    out_ready = 1'b1;
    set_in(1'b1, t.k, t.v, t.b, t.u, t.last);
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    step();
    chk({tag, "_lat2_valid"}, out_valid, 0);
    step();
    chk({tag, "_lat3_valid"}, out_valid, 1);
    chk({tag, "_y"}, out_y, t.y);
    chk({tag, "_last"}, out_last, t.last);
    step();
    chk({tag, "_one_cycle"}, out_valid, 0);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 12) begin
      step();
      n++;
    end
    step();
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{1024, 512, 1024, 0, 1, 1536};
    vecs[1] = '{1024, 512, 1024, 1, 0, 768};
    vecs[2] = '{1024, 512, 1024, 17, 1, 0};
    vecs[3] = '{1024, 512, 1024, 20, 0, 0};
    vecs[4] = '{262143, 1023, 262143, 0, 1, 262143};
    vecs[5] = '{262143, 1023, 262143, 2, 0, 65535};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_last", out_last, 0);
    #10 rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
    drain("directed");

    // backpressure: five beats, downstream stalls cycles 3..6
    begin
      int idx;
      bit fire;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
        out_ready = !(c >= 3 && c < 7);
        if (idx < 5) set_in(1'b1, 1024, 512, 1024, idx, idx == 4);
        else in_valid = 1'b0;
        @(negedge clk);
        if (c == 3) chk("bp_in_ready_full", in_ready, 0);
        if (c == 7) chk("bp_in_ready_free", in_ready, 1);
        fire = in_valid && in_ready;
        step();
        if (fire) idx++;
      end
      chk("bp_all_accepted", idx, 5);
    end
    drain("backpressure");

    // bubbles: alternate in_valid, output follows three cycles later
    begin
      bit iv[12];
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
        chk($sformatf("bub_out_valid_c%0d", c), out_valid,
            (c >= 3) ? iv[c-3] : 0);
        iv[c] = (c % 2) == 0;
        set_in(iv[c], 1024, 512, 1024, c % 4, c % 2);
        #1;
        chk("bub_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
      end
    end
    drain("bubbles");

    // asynchronous reset with three beats in flight
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 1024, 512, 1024, 0, 1);
      step();
    end
    in_valid = 1'b0;
    chk("rf_full_before", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_out_valid", out_valid, 0);
    chk("rf_out_y", out_y, 0);
    chk("rf_out_last", out_last, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("rf_no_stale", out_valid, 0);
      step();
    end
    apply_vec(vecs[1], "rf_new");
    drain("reset");

    // random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      int unsigned b;
      out_ready = $urandom_range(0, 3) != 0;
      b = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4095)
                                      : $urandom_range(0, 262143);
      set_in($urandom_range(0, 2) != 0, $urandom_range(0, 262143),
             $urandom_range(0, 1023), b, $urandom_range(0, 21),
             $urandom_range(0, 1) == 1);
      step();
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
